// File: rtl/hsiao_secded_codec.sv
// hsiao_secded_codec
// Parametrised SEC-DED codec with a 2-stage elastic valid/ready pipeline.
// Encode mode turns DATA_W data bits into a CODE_W-bit codeword. Decode mode
// checks a received codeword, corrects a single-bit error, flags a double
// error, and returns the data bits. Two saturating counters track the
// accepted results that reported a correction or an uncorrectable error.
//
// Codeword layout (1-based positions 1..CODE_W-1): parity bits at positions
// 2^k, data bits in the remaining positions in ascending order, and bit 0
// holding even parity over bits [CODE_W-1:1].
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   in_valid/in_ready       request handshake
//   in_mode                 0 = encode, 1 = decode (per transaction)
//   in_data[CODE_W-1:0]     encode: data in [DATA_W-1:0]; decode: codeword
//   out_valid/out_ready     result handshake
//   out_data[CODE_W-1:0]    encode: codeword; decode: data, upper bits 0
//   out_syndrome[P_W-1:0]   decode syndrome, 0 for encode
//   out_sec / out_ded       single error corrected / uncorrectable error
//   cnt_clr                 synchronous clear of both counters
//   err_cnt_sec/err_cnt_ded saturating error counters
module hsiao_secded_codec #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16,
  // Smallest r with 2^r >= DATA_W + r + 1, valid for DATA_W in 4..64.
  localparam int P_W    = (DATA_W <= 4)  ? 3 :
                          (DATA_W <= 11) ? 4 :
                          (DATA_W <= 26) ? 5 :
                          (DATA_W <= 57) ? 6 : 7,
  localparam int CODE_W = DATA_W + P_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mode,
  input  logic [CODE_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_data,
  output logic [P_W-1:0]    out_syndrome,
  output logic              out_sec,
  output logic              out_ded,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  err_cnt_sec,
  output logic [CNT_W-1:0]  err_cnt_ded
);

  logic              s1_valid_q;
  logic              s1_mode_q;
  logic [CODE_W-1:0] s1_code_q, s1_code_d;
  logic [P_W-1:0]    s1_syn_q, s1_syn_d;
  logic              s1_op_q, s1_op_d;
  logic [CODE_W-1:0] enc_word;

  logic              s2_valid_q;
  logic [CODE_W-1:0] s2_data_q, s2_data_d;
  logic [P_W-1:0]    s2_syn_q, s2_syn_d;
  logic              s2_sec_q, s2_sec_d;
  logic              s2_ded_q, s2_ded_d;

  logic [CNT_W-1:0]  cnt_sec_q, cnt_sec_d;
  logic [CNT_W-1:0]  cnt_ded_q, cnt_ded_d;

  logic s1_load, s2_load, out_hs;

  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;
  assign out_hs   = s2_valid_q && out_ready;

  // Stage 1 front end: build the codeword for encode, syndrome and overall
  // parity for decode. Both are computed every cycle; mode picks what is kept.
  always_comb begin : enc_calc
    int  di;
    logic par;
    enc_word = '0;
    di       = 0;
    for (int j = 1; j < CODE_W; j++) begin
      if ((j & (j - 1)) != 0) begin
        enc_word[j] = in_data[di];
        di = di + 1;
      end
    end
    // Parity positions never have bit k set for any other parity index, so
    // filling them in ascending k order does not disturb later sums.
    for (int k = 0; k < P_W; k++) begin
      par = 1'b0;
      for (int j = 1; j < CODE_W; j++) begin
        if (((j >> k) & 1) != 0) par = par ^ enc_word[j];
      end
      enc_word[1 << k] = par;
    end
    enc_word[0] = ^enc_word[CODE_W-1:1];
  end

  always_comb begin
    s1_syn_d = '0;
    for (int k = 0; k < P_W; k++) begin
      for (int j = 1; j < CODE_W; j++) begin
        if (((j >> k) & 1) != 0) s1_syn_d[k] = s1_syn_d[k] ^ in_data[j];
      end
    end
    s1_op_d   = ^in_data;
    s1_code_d = in_mode ? in_data : enc_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= 1'b0;
      s1_code_q  <= '0;
      s1_syn_q   <= '0;
      s1_op_q    <= 1'b0;
    end else if (s1_load) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_mode_q <= in_mode;
        s1_code_q <= s1_code_d;
        s1_syn_q  <= s1_syn_d;
        s1_op_q   <= s1_op_d;
      end
    end
  end

  // Stage 2 front end: classify, correct and extract the data bits.
  always_comb begin : dec_calc
    int di;
    logic [CODE_W-1:0] fixed;
    s2_data_d = '0;
    s2_syn_d  = '0;
    s2_sec_d  = 1'b0;
    s2_ded_d  = 1'b0;
    fixed     = s1_code_q;
    di        = 0;
    if (!s1_mode_q) begin
      s2_data_d = s1_code_q;
    end else begin
      s2_syn_d = s1_syn_q;
      if (s1_op_q && (int'(s1_syn_q) < CODE_W)) begin
        // Odd error count with an in-range syndrome: single error. A zero
        // syndrome means bit 0 itself flipped and the data is already good.
        s2_sec_d = 1'b1;
        for (int j = 1; j < CODE_W; j++) begin
          if (int'(s1_syn_q) == j) fixed[j] = ~fixed[j];
        end
      end else if (s1_op_q || (s1_syn_q != '0)) begin
        s2_ded_d = 1'b1;
      end
      for (int j = 1; j < CODE_W; j++) begin
        if ((j & (j - 1)) != 0) begin
          s2_data_d[di] = fixed[j];
          di = di + 1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_syn_q   <= '0;
      s2_sec_q   <= 1'b0;
      s2_ded_q   <= 1'b0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_data_q <= s2_data_d;
        s2_syn_q  <= s2_syn_d;
        s2_sec_q  <= s2_sec_d;
        s2_ded_q  <= s2_ded_d;
      end
    end
  end

  // Clear has priority over a same-cycle increment.
  always_comb begin
    cnt_sec_d = cnt_sec_q;
    cnt_ded_d = cnt_ded_q;
    if (cnt_clr) begin
      cnt_sec_d = '0;
      cnt_ded_d = '0;
    end else if (out_hs) begin
      if (s2_sec_q && (cnt_sec_q != '1)) cnt_sec_d = cnt_sec_q + CNT_W'(1);
      if (s2_ded_q && (cnt_ded_q != '1)) cnt_ded_d = cnt_ded_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_sec_q <= '0;
      cnt_ded_q <= '0;
    end else begin
      cnt_sec_q <= cnt_sec_d;
      cnt_ded_q <= cnt_ded_d;
    end
  end

  assign out_valid    = s2_valid_q;
  assign out_data     = s2_data_q;
  assign out_syndrome = s2_syn_q;
  assign out_sec      = s2_sec_q;
  assign out_ded      = s2_ded_q;
  assign err_cnt_sec  = cnt_sec_q;
  assign err_cnt_ded  = cnt_ded_q;

endmodule

// File: tb/tb_hsiao_secded_codec.sv
// Testbench for hsiao_secded_codec: DATA_W=8 directed and randomized checks,
// plus DATA_W=16 (3-bit counters), 32 and 64 random streams.
module tb_hsiao_secded_codec;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [127:0] data;
    logic [7:0]   syn;
    logic         sec;
    logic         ded;
  } exp_t;

  // DATA_W = 8
  logic        iv8, ir8, im8, ov8, or8, sec8, ded8, clr8;
  logic [12:0] id8, od8;
  logic [3:0]  os8;
  logic [15:0] cs8, cd8;

  hsiao_secded_codec #(.DATA_W(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .in_mode(im8),
    .in_data(id8), .out_valid(ov8), .out_ready(or8), .out_data(od8),
    .out_syndrome(os8), .out_sec(sec8), .out_ded(ded8), .cnt_clr(clr8),
    .err_cnt_sec(cs8), .err_cnt_ded(cd8));

  // Wide instances share the handshake strobes.
  logic ivw, orw, clrw;

  logic        ir16, im16, ov16, sec16, ded16;
  logic [21:0] id16, od16;
  logic [4:0]  os16;
  logic [2:0]  cs16, cd16;

  hsiao_secded_codec #(.DATA_W(16), .CNT_W(3)) u_d16 (
    .clk(clk), .rst_n(rst_n), .in_valid(ivw), .in_ready(ir16), .in_mode(im16),
    .in_data(id16), .out_valid(ov16), .out_ready(orw), .out_data(od16),
    .out_syndrome(os16), .out_sec(sec16), .out_ded(ded16), .cnt_clr(clrw),
    .err_cnt_sec(cs16), .err_cnt_ded(cd16));

  logic        ir32, im32, ov32, sec32, ded32;
  logic [38:0] id32, od32;
  logic [5:0]  os32;
  logic [15:0] cs32, cd32;

  hsiao_secded_codec #(.DATA_W(32)) u_d32 (
    .clk(clk), .rst_n(rst_n), .in_valid(ivw), .in_ready(ir32), .in_mode(im32),
    .in_data(id32), .out_valid(ov32), .out_ready(orw), .out_data(od32),
    .out_syndrome(os32), .out_sec(sec32), .out_ded(ded32), .cnt_clr(clrw),
    .err_cnt_sec(cs32), .err_cnt_ded(cd32));

  logic        ir64, im64, ov64, sec64, ded64;
  logic [71:0] id64, od64;
  logic [6:0]  os64;
  logic [15:0] cs64, cd64;

  hsiao_secded_codec #(.DATA_W(64)) u_d64 (
    .clk(clk), .rst_n(rst_n), .in_valid(ivw), .in_ready(ir64), .in_mode(im64),
    .in_data(id64), .out_valid(ov64), .out_ready(orw), .out_data(od64),
    .out_syndrome(os64), .out_sec(sec64), .out_ded(ded64), .cnt_clr(clrw),
    .err_cnt_sec(cs64), .err_cnt_ded(cd64));

  // ---------------- reference model ----------------
  function automatic int pw_of(input int dw);
    int r = 1;
    while ((1 << r) < dw + r + 1) r++;
    return r;
  endfunction

  // Parity bit k equals bit k of the XOR of the positions holding a data 1.
  function automatic logic [127:0] ref_enc(input logic [127:0] d, input int dw);
    int cw = dw + pw_of(dw) + 1;
    int x = 0;
    int di = 0;
    logic [127:0] c = '0;
    for (int j = 1; j < cw; j++) begin
      if ((j & (j - 1)) != 0) begin
        c[j] = d[di];
        if (d[di]) x = x ^ j;
        di++;
      end
    end
    for (int k = 0; (1 << k) < cw; k++) c[1 << k] = x[k];
    c[0] = ^c;
    return c;
  endfunction

  // Syndrome = XOR of the positions of all set bits in 1..cw-1.
  function automatic void ref_dec(input logic [127:0] c, input int dw,
                                  output logic [127:0] data, output logic [7:0] syn,
                                  output logic sec, output logic ded);
    int cw = dw + pw_of(dw) + 1;
    int s = 0;
    int di = 0;
    logic op;
    logic [127:0] f;
    op = ^c;
    for (int j = 1; j < cw; j++) if (c[j]) s = s ^ j;
    f = c;
    sec = 1'b0;
    ded = 1'b0;
    if (op && s < cw) begin
      sec = 1'b1;
      if (s != 0) f[s] = ~f[s];
    end else if (op || s != 0) begin
      ded = 1'b1;
    end
    data = '0;
    for (int j = 1; j < cw; j++) begin
      if ((j & (j - 1)) != 0) begin
        data[di] = f[j];
        di++;
      end
    end
    syn = 8'(s);
  endfunction

  function automatic void exp8(input logic m, input logic [12:0] din,
                               output logic [127:0] d, output logic [7:0] s,
                               output logic sec, output logic ded);
    logic [127:0] dd;
    if (m) begin
      ref_dec(128'(din), 8, d, s, sec, ded);
    end else begin
      dd = 128'(din[7:0]);
      d = ref_enc(dd, 8);
      s = '0;
      sec = 1'b0;
      ded = 1'b0;
    end
  endfunction

  function automatic int sat_inc(input int v, input int maxv);
    return (v < maxv) ? v + 1 : v;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- DATA_W=8 helpers ----------------
  int ecs8 = 0, ecd8 = 0;
  logic [12:0] last_od8;
  logic [3:0]  last_os8;

  task automatic run8(input string tag, input logic mode, input logic [12:0] din,
                      input logic do_clr);
    logic [127:0] ed;
    logic [7:0] es;
    logic esec, eded;
    exp8(mode, din, ed, es, esec, eded);
    @(negedge clk);
    im8 = mode; id8 = din; iv8 = 1'b1; or8 = 1'b1;
    #1;
    chk({tag, "_in_ready"}, ir8, 1'b1);
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
    #1;
    chk({tag, "_lat1_valid"}, ov8, 1'b0);
    @(posedge clk);
    @(negedge clk);
    clr8 = do_clr;
    #1;
    chk({tag, "_valid"}, ov8, 1'b1);
    chk({tag, "_data"}, od8, ed);
    chk({tag, "_syn"}, os8, es);
    chk({tag, "_sec"}, sec8, esec);
    chk({tag, "_ded"}, ded8, eded);
    last_od8 = od8;
    last_os8 = os8;
    @(posedge clk);
    if (do_clr) begin
      ecs8 = 0;
      ecd8 = 0;
    end else begin
      if (esec) ecs8 = sat_inc(ecs8, 65535);
      if (eded) ecd8 = sat_inc(ecd8, 65535);
    end
    @(negedge clk);
    clr8 = 1'b0;
    #1;
    chk({tag, "_cnt_sec"}, cs8, ecs8);
    chk({tag, "_cnt_ded"}, cd8, ecd8);
  endtask

  // ---------------- wide stream helpers ----------------
  localparam int NW = 120;
  exp_t ew[3][NW];
  int ecs[3], ecd[3];

  task automatic gen_w(input int w, input int idx, output logic mode,
                       output logic [127:0] din);
    int dw = 16 << w;
    int cw = dw + pw_of(dw) + 1;
    int kind, p, q;
    logic [127:0] data, code, ed;
    logic [7:0] es;
    logic esec, eded;
    data = {$urandom, $urandom, $urandom, $urandom} & ((128'd1 << dw) - 1);
    code = ref_enc(data, dw);
    mode = 1'($urandom_range(0, 1));
    if (!mode) begin
      din = data | ((128'($urandom) << dw) & ((128'd1 << cw) - 1));
      ew[w][idx] = '{code, 8'd0, 1'b0, 1'b0};
    end else begin
      kind = int'($urandom_range(0, 2));
      p = int'($urandom_range(0, cw - 1));
      q = (p + 1 + int'($urandom_range(0, cw - 2))) % cw;
      din = code;
      if (kind >= 1) din[p] = ~din[p];
      if (kind == 2) din[q] = ~din[q];
      ref_dec(din, dw, ed, es, esec, eded);
      ew[w][idx] = '{ed, es, esec, eded};
    end
  endtask

  task automatic chk_w(input string tag, input int w, input logic ov,
                       input logic [127:0] od, input logic [7:0] os,
                       input logic sec, input logic ded, input int idx);
    int cmax = (w == 0) ? 7 : 65535;
    chk({tag, "_valid"}, ov, 1'b1);
    chk({tag, "_data"}, od, ew[w][idx].data);
    chk({tag, "_syn"}, os, ew[w][idx].syn);
    chk({tag, "_sec"}, sec, ew[w][idx].sec);
    chk({tag, "_ded"}, ded, ew[w][idx].ded);
    if (ew[w][idx].sec) ecs[w] = sat_inc(ecs[w], cmax);
    if (ew[w][idx].ded) ecd[w] = sat_inc(ecd[w], cmax);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  logic [127:0] tmp, bpd[4];
  logic [7:0]   bps[4];
  logic         bpsec[4], bpded[4], bpm[4], acc, m;
  logic [12:0]  bpi[4];
  int sent, got;

  initial begin
    rst_n = 1'b0;
    iv8 = 0; im8 = 0; id8 = '0; or8 = 1'b1; clr8 = 0;
    ivw = 0; orw = 1'b1; clrw = 0;
    id16 = '0; im16 = 0; id32 = '0; im32 = 0; id64 = '0; im64 = 0;
    for (int w = 0; w < 3; w++) begin ecs[w] = 0; ecd[w] = 0; end
    #1;
    chk("rst_out_valid", ov8, 1'b0);
    chk("rst_out_data", od8, 13'h0);
    chk("rst_cnt_sec", cs8, 16'h0);
    chk("rst_cnt_ded", cd8, 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", ir8, 1'b1);

    // Reference point of the 8-bit layout.
    run8("enc_a5", 1'b0, 13'h0A5, 1'b0);
    chk("enc_a5_literal", last_od8, 13'h144E);

    // All 256 encodes back to back; upper input bits carry junk.
    for (int i = 0; i < 258; i++) begin
      @(negedge clk);
      #1;
      if (i >= 2) begin
        tmp = ref_enc(128'(i - 2), 8);
        chk("sweep_valid", ov8, 1'b1);
        chk("sweep_data", od8, tmp);
        chk("sweep_in_ready", ir8, 1'b1);
      end
      if (i < 256) begin
        iv8 = 1'b1; im8 = 1'b0; id8 = {5'($urandom), 8'(i)};
      end else begin
        iv8 = 1'b0;
      end
    end
    @(negedge clk);

    run8("dec_bit6", 1'b1, 13'h140E, 1'b0);
    chk("dec_bit6_literal", last_od8, 13'h0A5);
    chk("dec_bit6_syn_literal", last_os8, 4'd6);
    chk("dec_bit6_cnt_literal", cs8, 16'd1);
    run8("dec_bit0", 1'b1, 13'h144F, 1'b0);
    chk("dec_bit0_literal", last_od8, 13'h0A5);
    chk("dec_bit0_cnt_literal", cs8, 16'd2);
    run8("dec_dbl01", 1'b1, 13'h144D, 1'b0);
    chk("dec_dbl01_syn_literal", last_os8, 4'd1);
    run8("dec_triple", 1'b1, 13'h155C, 1'b0);
    chk("dec_triple_syn_literal", last_os8, 4'd13);
    chk("dec_triple_cnt_literal", cd8, 16'd2);
    run8("dec_clean", 1'b1, 13'h144E, 1'b0);

    // Clear coinciding with a SEC handshake.
    run8("clr_with_sec", 1'b1, 13'h140E, 1'b1);
    chk("clr_with_sec_literal", cs8, 16'd0);
    run8("sec_after_clr", 1'b1, 13'h144F, 1'b0);

    // Backpressure with mixed modes.
    bpm[0] = 1'b0; bpi[0] = 13'h003C;
    tmp = ref_enc(128'h5A, 8); tmp[9] = ~tmp[9];
    bpm[1] = 1'b1; bpi[1] = tmp[12:0];
    tmp = ref_enc(128'h81, 8); tmp[2] = ~tmp[2]; tmp[7] = ~tmp[7];
    bpm[2] = 1'b1; bpi[2] = tmp[12:0];
    bpm[3] = 1'b0; bpi[3] = 13'h1F0F;
    for (int k = 0; k < 4; k++) exp8(bpm[k], bpi[k], bpd[k], bps[k], bpsec[k], bpded[k]);
    sent = 0;
    got = 0;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      @(negedge clk);
      or8 = (cyc >= 5);
      iv8 = (sent < 4);
      if (sent < 4) begin im8 = bpm[sent]; id8 = bpi[sent]; end
      #1;
      if (cyc >= 2 && cyc < 5) begin
        chk("bp_in_ready_low", ir8, 1'b0);
        chk("bp_hold_valid", ov8, 1'b1);
        chk("bp_hold_data", od8, bpd[0]);
        chk("bp_hold_syn", os8, bps[0]);
      end
      if (ov8 && or8 && got < 4) begin
        chk("bp_out_data", od8, bpd[got]);
        chk("bp_out_syn", os8, bps[got]);
        chk("bp_out_sec", sec8, bpsec[got]);
        chk("bp_out_ded", ded8, bpded[got]);
        if (bpsec[got]) ecs8 = sat_inc(ecs8, 65535);
        if (bpded[got]) ecd8 = sat_inc(ecd8, 65535);
        got++;
      end
      acc = iv8 && ir8;
      @(posedge clk);
      if (acc) sent++;
    end
    @(negedge clk);
    iv8 = 1'b0;
    #1;
    chk("bp_results_count", got, 4);
    chk("bp_no_duplicate", ov8, 1'b0);
    chk("bp_cnt_sec", cs8, ecs8);
    chk("bp_cnt_ded", cd8, ecd8);

    // Wide random streams, one request per cycle.
    for (int i = 0; i < NW + 2; i++) begin
      @(negedge clk);
      #1;
      if (i >= 2) begin
        chk_w("w16", 0, ov16, 128'(od16), 8'(os16), sec16, ded16, i - 2);
        chk_w("w32", 1, ov32, 128'(od32), 8'(os32), sec32, ded32, i - 2);
        chk_w("w64", 2, ov64, 128'(od64), 8'(os64), sec64, ded64, i - 2);
      end else begin
        chk("w16_lat_valid", ov16, 1'b0);
        chk("w64_lat_valid", ov64, 1'b0);
      end
      if (i < NW) begin
        ivw = 1'b1;
        gen_w(0, i, m, tmp); im16 = m; id16 = tmp[21:0];
        gen_w(1, i, m, tmp); im32 = m; id32 = tmp[38:0];
        gen_w(2, i, m, tmp); im64 = m; id64 = tmp[71:0];
      end else begin
        ivw = 1'b0;
      end
    end
    @(negedge clk);
    #1;
    chk("w16_cnt_sec_sat", cs16, ecs[0]);
    chk("w16_cnt_ded_sat", cd16, ecd[0]);
    chk("w32_cnt_sec", cs32, ecs[1]);
    chk("w32_cnt_ded", cd32, ecd[1]);
    chk("w64_cnt_sec", cs64, ecs[2]);
    chk("w64_cnt_ded", cd64, ecd[2]);

    // Asynchronous reset with two transactions in flight.
    @(negedge clk);
    or8 = 1'b0; iv8 = 1'b1; im8 = 1'b0; id8 = 13'h0033;
    @(negedge clk);
    im8 = 1'b1; id8 = 13'h140E;
    @(negedge clk);
    iv8 = 1'b0;
    #1;
    chk("rst_pre_valid", ov8, 1'b1);
    chk("rst_pre_cnt_sec", cs8, ecs8);
    #2;
    rst_n = 1'b0;
    #1;
    ecs8 = 0;
    ecd8 = 0;
    chk("rst_mid_valid", ov8, 1'b0);
    chk("rst_mid_data", od8, 13'h0);
    chk("rst_mid_cnt_sec", cs8, 16'h0);
    chk("rst_mid_cnt_ded", cd8, 16'h0);
    chk("rst_mid_sec", sec8, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    or8 = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_discard_valid", ov8, 1'b0);
    run8("enc_a5_after_rst", 1'b0, 13'h0A5, 1'b0);
    chk("enc_a5_after_rst_literal", last_od8, 13'h144E);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hsiao_secded_codec.md
Name: hsiao_secded_codec

Overview:
Parametrised, pipelined SEC-DED codec: the next generation of the 8-bit combinational encoder, generalised to any data width and extended with a decode/correct mode. Each transaction selects encode or decode, flows through a 2-stage elastic pipeline with valid/ready handshakes, and updates saturating error counters. It sits between the memory controller datapath and the SRAM macro: encoding on the write path, checking and correcting on the read path.

Parameters:
DATA_W, 8, data bits per word (4..64)
P_W, derived, parity bits: smallest r with 2^r >= DATA_W+r+1 (4 for DATA_W=8)
CODE_W, derived, DATA_W+P_W+1 (13 for DATA_W=8)
CNT_W, 16, width of each error counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  request accepted when in_valid&&in_ready
in_mode  input  1  0=encode, 1=decode; sampled with request
in_data  input  CODE_W  encode: data in [DATA_W-1:0], upper bits ignored; decode: received codeword
out_valid  output  1  result valid
out_ready  input  1  result consumed when out_valid&&out_ready
out_data  output  CODE_W  encode: codeword; decode: corrected data in [DATA_W-1:0], upper bits 0
out_syndrome  output  P_W  decode: syndrome; encode: 0
out_sec  output  1  decode: single error corrected
out_ded  output  1  decode: uncorrectable error
cnt_clr  input  1  synchronous clear of both counters
err_cnt_sec  output  CNT_W  saturating count of accepted results with out_sec=1
err_cnt_ded  output  CNT_W  saturating count of accepted results with out_ded=1

Behaviour:
- Codeword layout, 1-based positions 1..CODE_W-1: parity at positions 2^k (k=0..P_W-1); data bits fill the remaining positions in ascending order, data[0] at lowest. Bit 0 is even parity over bits [CODE_W-1:1]. For DATA_W=8 the layout is identical to the existing 13-bit encoder.
- Parity at position 2^k = XOR of all data positions j with bit k of j set.
- Decode:
  - s[k] = XOR of code[j] over j in 1..CODE_W-1 with bit k of j set.
  - op = XOR of all CODE_W bits.
  - op=0, s=0: clean, sec=0, ded=0.
  - op=1, s=0: bit 0 in error, data unchanged, sec=1.
  - op=1, 1<=s<=CODE_W-1: flip position s, sec=1.
  - op=1, s>CODE_W-1: ded=1, data passed uncorrected.
  - op=0, s!=0: ded=1, data passed uncorrected.
  - sec and ded are never both 1.
- Pipeline:
  - Stage 1 registers the request and computes parity/syndrome.
  - Stage 2 registers the corrected result and flags.
  - Each stage loads when it is empty or its contents are moving on.
  - in_ready = !s1_valid || s2_load, where s2_load = !s2_valid || out_ready.
  - Latency is 2 cycles from accept to out_valid with no stall. Throughput is 1 per cycle.
- Handshake: out_data, flags and syndrome hold stable while out_valid&&!out_ready. The pipeline holds 2 transactions max; none are dropped or duplicated. Mode is per transaction, so mixed modes back-to-back are allowed.
- Counters:
  - Increment on an output handshake with the matching flag.
  - Saturate at 2^CNT_W-1.
  - cnt_clr in the same cycle as an increment: clear wins, counter becomes 0.
- Reset, asynchronous and valid mid-transfer: s1_valid, s2_valid, out_valid, out_sec, out_ded, out_syndrome, out_data and both counters go to 0; in-flight data is discarded. in_ready is 1 after reset deasserts.

Test Plan:
- Encode in_data=0xA5, out_ready=1 -> out_data=0x144E two cycles after accept, syndrome 0, sec=0, ded=0. Sweep all 256 values against the 8-bit encoder model: must match.
- Decode 0x140E (bit 6 flipped) -> out_data=0x0A5, syndrome=6, sec=1, err_cnt_sec=1. Decode 0x144F (bit 0 flipped) -> 0x0A5, syndrome=0, sec=1, err_cnt_sec=2.
- Decode 0x144D (bits 0,1 flipped) -> ded=1, syndrome=1. Decode 0x155C (bits 1,4,8 flipped, s=13>12) -> ded=1, data uncorrected; err_cnt_ded=2.
- Backpressure: stream 4 mixed-mode requests with out_ready=0 for 5 cycles -> in_ready drops after 2 accepts, outputs held stable; release -> all 4 emerge in order, correct, no loss.
- Counters: force err_cnt_sec to 0xFFFF then another SEC -> stays 0xFFFF; cnt_clr with a simultaneous SEC handshake -> 0.
- Reset asserted with 2 transactions in flight -> out_valid=0 and counters=0 immediately; after release, encode 0xA5 -> 0x144E.
- Parametric regression: DATA_W=16,32,64 with random data and random single/double flips -> all singles corrected, all doubles flagged ded.
